// File: rtl/serial_addr_decoder_if.sv
// Serial system bus between the granted master, the address decoder and the slaves.
// The slave modport is the decoder's view; the master modport is the driving side.
interface serial_addr_decoder_if #(
  parameter int NUM_SLAVES = 3
);
  logic                  mbgrant;
  logic                  mvalid;
  logic                  mwdata;
  logic                  svalid;
  logic                  mrdata;
  logic [NUM_SLAVES-1:0] mvalid_s;
  logic [NUM_SLAVES-1:0] svalid_s;
  logic [NUM_SLAVES-1:0] srdata_s;
  logic [NUM_SLAVES-1:0] ssel;
  logic                  dec_err;

  modport master (
    output mbgrant, mvalid, mwdata, svalid_s, srdata_s,
    input  svalid, mrdata, mvalid_s, ssel, dec_err
  );

  modport slave (
    input  mbgrant, mvalid, mwdata, svalid_s, srdata_s,
    output svalid, mrdata, mvalid_s, ssel, dec_err
  );
endinterface

// File: rtl/serial_addr_decoder.sv
// Decodes the LSB-first slave ID heading each granted transaction into a registered one-hot select,
// then routes mvalid to that slave and muxes its read bit back with no added latency.
module serial_addr_decoder #(
  parameter int NUM_SLAVES = 3,
  parameter int ID_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  serial_addr_decoder_if.slave   bus
);
  localparam int CW = $clog2(ID_WIDTH + 1);
  localparam logic [CW-1:0]       C_LAST = CW'(ID_WIDTH - 1);
  localparam logic [ID_WIDTH:0]   C_NS   = (ID_WIDTH + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CONNECT, S_ERROR} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [NUM_SLAVES-1:0] r_ssel;
  logic                  r_dec_err;

  logic [ID_WIDTH-1:0]   w_id_next;
  logic                  w_id_ok;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_conn;

  // r_id is cleared on every IDLE entry, so OR-ing the bit into its slot is a clean LSB-first shift.
  assign w_id_next = r_id | (ID_WIDTH'(bus.mwdata) << r_cnt);
  assign w_id_ok   = ({1'b0, w_id_next} < C_NS);
  assign w_onehot  = NUM_SLAVES'(1) << w_id_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_id      <= '0;
      r_ssel    <= '0;
      r_dec_err <= 1'b0;
    end else begin
      r_dec_err <= 1'b0;
      if (!bus.mbgrant) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_id    <= '0;
        r_ssel  <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_ADDR: begin
            r_state <= S_ADDR;
            if (bus.mvalid) begin
              r_id  <= w_id_next;
              r_cnt <= r_cnt + CW'(1);
              if (r_cnt == C_LAST) begin
                if (w_id_ok) begin
                  r_ssel  <= w_onehot;
                  r_state <= S_CONNECT;
                end else begin
                  r_state   <= S_ERROR;
                  r_dec_err <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign w_conn       = (r_state == S_CONNECT);
  assign bus.mvalid_s = w_conn ? (r_ssel & {NUM_SLAVES{bus.mvalid}}) : '0;
  assign bus.svalid   = w_conn & (|(bus.svalid_s & r_ssel));
  assign bus.mrdata   = w_conn & (|(bus.srdata_s & r_ssel));
  assign bus.ssel     = r_ssel;
  assign bus.dec_err  = r_dec_err;
endmodule

// File: tb/tb_serial_addr_decoder.sv
// Directed bench: a vector table for error/gap/ID=0 sequences plus hand-written
// sequences for payload routing, read muxing, grant loss mid-ID and async reset.
module tb_serial_addr_decoder;
  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  serial_addr_decoder_if #(.NUM_SLAVES(3)) bus ();

  serial_addr_decoder #(.NUM_SLAVES(3), .ID_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       g;
    logic       v;
    logic       d;
    logic [2:0] svs;
    logic [2:0] srs;
    logic [2:0] mvs;
    logic       sv;
    logic       mr;
    logic [2:0] ssel;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string nm, input logic [2:0] mvs, input logic sv, input logic mr,
                            input logic [2:0] ssel, input logic err);
    chk({nm, ".mvalid_s"}, {5'b0, bus.mvalid_s}, {5'b0, mvs});
    chk({nm, ".svalid"},   {7'b0, bus.svalid},   {7'b0, sv});
    chk({nm, ".mrdata"},   {7'b0, bus.mrdata},   {7'b0, mr});
    chk({nm, ".ssel"},     {5'b0, bus.ssel},     {5'b0, ssel});
    chk({nm, ".dec_err"},  {7'b0, bus.dec_err},  {7'b0, err});
  endtask

  // Drive one cycle's inputs after the falling edge and check outputs before the next rising edge.
  task automatic step(input logic g, input logic v, input logic d, input logic [2:0] svs,
                      input logic [2:0] srs, input logic [2:0] mvs, input logic sv, input logic mr,
                      input logic [2:0] ssel, input logic err, input string nm);
    @(negedge clk);
    bus.mbgrant  = g;
    bus.mvalid   = v;
    bus.mwdata   = d;
    bus.svalid_s = svs;
    bus.srdata_s = srs;
    #1;
    check_outs(nm, mvs, sv, mr, ssel, err);
  endtask

  task automatic send_id(input logic [3:0] id);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, id[i], 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "id_bit");
  endtask

  task automatic drop_grant(input logic [2:0] cur_ssel);
    step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, cur_ssel, 1'b0, "drop");
    step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "idle");
  endtask

  initial begin
    int         pulses;
    int         stray;
    logic [7:0] pat;
    logic [7:0] rd;

    n_vec = 0;
    n_err = 0;
    rstn         = 1'b0;
    bus.mbgrant  = 1'b0;
    bus.mvalid   = 1'b0;
    bus.mwdata   = 1'b0;
    bus.svalid_s = 3'b000;
    bus.srdata_s = 3'b000;
    #2;
    check_outs("reset", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // g v d svs srs | mvs sv mr ssel err
    // ID=5 (1,0,1,0): out of range
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    // ID=0 after the error tenure
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0});
    // ID=2 (0,1,0,0) with two-cycle gaps; gap data is 1 to expose gap sampling
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 3'b100, 1'b1, 1'b1, 3'b100, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].g, tbl[i].v, tbl[i].d, tbl[i].svs, tbl[i].srs, tbl[i].mvs, tbl[i].sv,
           tbl[i].mr, tbl[i].ssel, tbl[i].err, $sformatf("tbl[%0d]", i));

    // ID=1 then 20 payload bits, all on slave 1
    send_id(4'd1);
    pulses = 0;
    stray  = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, i[0], 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, "t1_payload");
      pulses += int'(bus.mvalid_s[1]);
      stray  += int'(bus.mvalid_s[0]) + int'(bus.mvalid_s[2]);
    end
    chk("t1_pulses", 8'(pulses), 8'd20);
    chk("t1_stray", 8'(stray), 8'd0);
    drop_grant(3'b010);

    // ID=2 read of 8'hA5 with slave 0 also driving
    send_id(4'd2);
    pat = 8'hA5;
    rd  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 3'b101, {pat[i], 1'b0, 1'b1}, 3'b000, 1'b1, pat[i], 3'b100, 1'b0,
           "t2_read");
      rd[i] = bus.mrdata;
    end
    chk("t2_byte", rd, 8'hA5);
    step(1'b1, 1'b0, 1'b0, 3'b011, 3'b011, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, "t2_unsel");
    drop_grant(3'b100);

    // grant lost after two ID bits, then a clean ID=1
    step(1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "t5_partial");
    step(1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "t5_partial");
    drop_grant(3'b000);
    send_id(4'd1);
    step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, "t5_decode");
    drop_grant(3'b010);

    // asynchronous reset in the middle of a connected tenure
    send_id(4'd0);
    step(1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0, "t6_conn");
    #1 rstn = 1'b0;
    #1 check_outs("t6_async", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    bus.mbgrant  = 1'b0;
    bus.mvalid   = 1'b0;
    bus.svalid_s = 3'b000;
    bus.srdata_s = 3'b000;
    @(negedge clk);
    rstn = 1'b1;
    send_id(4'd0);
    step(1'b1, 1'b1, 1'b0, 3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0, "t6_after");
    drop_grant(3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
